rpn_stack_ctrl: RTL
===================

Name: rpn_stack_ctrl

Overview:
Sequencer for the RPN calculator's operand stack: accepts one command at a time (push operand, arithmetic op, pop, clear) and drives a synchronous-read stack RAM plus the stack-pointer register. Binary ops pop two entries, compute in an internal ALU, and push the result. It sits between the KEY/SW front-end command decoder and the stack RAM, and exposes SP/TOS for LEDR/HEX display.

Parameters:
DATA_W, 8, operand/result width
DEPTH, 16, stack entries (power of 2, >=4); ADDR_W = clog2(DEPTH) is a localparam

Ports:
CLOCK_50  in  1  system clock, all logic on posedge
reset  in  1  synchronous, active-high
cmd_valid  in  1  command present
cmd_ready  out  1  high only in IDLE
cmd_op  in  3  0 PUSH, 1 ADD, 2 SUB, 3 MUL, 4 AND, 5 POP, 6 CLR, 7 DUP (optional)
cmd_data  in  DATA_W  operand for PUSH
mem_addr  out  ADDR_W  stack RAM address
mem_we  out  1  RAM write strobe
mem_wdata  out  DATA_W  RAM write data
mem_rdata  in  DATA_W  RAM read data, valid 1 cycle after mem_addr
sp  out  ADDR_W+1  entry count, 0..DEPTH
tos  out  DATA_W  top-of-stack value (0 when sp==0)
done  out  1  1-cycle pulse when a command retires
err  out  2  valid with done: 0 OK, 1 underflow, 2 overflow, 3 illegal op

Behaviour:
- Reset: state IDLE, sp=0, tos=0, done=0, err=0, mem_we=0, mem_addr=0, mem_wdata=0. Reset mid-command aborts it: no write in the reset cycle and no done pulse.
- Accept on cmd_valid && cmd_ready (cycle T0); cmd_op/cmd_data are latched at T0.
- States: IDLE, PUSH_WR, RD_B, RD_A, EXEC, RES_WR, POP_RD, POP_CAP, RETIRE.
- PUSH: T1 PUSH_WR drives mem_we=1, addr=sp, wdata=operand; sp+1 and tos=operand at end of T1. T2 RETIRE: done=1. Latency 2.
- Binary op (ADD/SUB/MUL/AND): T1 RD_B addr=sp-1; T2 RD_A addr=sp-2, capture B; T3 EXEC capture A, compute R; T4 RES_WR we=1, addr=sp-2, wdata=R, sp-1, tos=R; T5 RETIRE. Latency 5.
- Arithmetic is modulo 2^DATA_W: SUB is A-B (A deeper, B top) and wraps; MUL keeps the low DATA_W bits; AND is bitwise.
- POP: sp-1. If the new sp is >0, read addr new_sp-1 (POP_RD) and capture it into tos (POP_CAP), then RETIRE (latency 4). If the new sp is 0, tos=0 and go straight to RETIRE (latency 2).
- CLR: sp=0, tos=0 in T1, RETIRE in T2. No RAM writes; old contents are ignored.
- Error checks at T0; an erroring command goes straight to RETIRE with no state change and no mem_we:
  - PUSH with sp==DEPTH -> err=2.
  - Binary op with sp<2 -> err=1.
  - POP with sp==0 -> err=1.
  - op 7 with the DUP feature absent -> err=3.
- mem_we is only ever high in PUSH_WR/RES_WR. mem_addr holds its last value otherwise.
- sp never exceeds DEPTH or goes below 0. Address arithmetic uses ADDR_W bits, and the guards above prevent wrap.
- cmd_valid during a busy period is ignored; the requester holds it until cmd_ready.

Optional Feature:
RPN_DUP_EN: when defined, op 7 DUP pushes a copy of tos. It writes tos at addr sp and sets sp+1 (latency 2). It raises err=2 if sp==DEPTH and err=1 if sp==0. When not defined, op 7 retires with err=3 and no state change.

Decomposition:
- Package rpn_pkg: opcode localparams (OP_PUSH..OP_DUP), err code localparams, state encoding.
- Sub-module rpn_alu: combinational, (op, a, b) -> r, DATA_W parameterised. The controller instantiates it in EXEC.

Test Plan:
- Reset, PUSH 5, PUSH 3, ADD -> sp 1, tos 8, RAM[0]=8, done 5 cycles after the ADD accept, err 0.
- PUSH 3, PUSH 5, SUB -> tos 0xFE (wrap); PUSH 0x20, PUSH 0x10, MUL -> tos 0x00 (low byte of 0x200).
- DEPTH=16: 16 PUSHes OK, 17th -> err=2, sp stays 16, no mem_we; then POP -> sp 15, tos = 15th operand.
- Empty stack: ADD -> err=1; PUSH 7, SUB -> err=1, sp stays 1, tos stays 7; POP twice -> second gives err=1.
- Assert reset during RES_WR of an ADD -> next cycle mem_we=0, sp=0, tos=0, no done; a following PUSH 9 works normally.
- op 7 with sp=1, tos=4: with RPN_DUP_EN -> sp 2, RAM[1]=4; without it -> err=3, sp 1.

Source files
------------

// File: rtl/rpn_pkg.sv
// Shared opcodes, error codes and controller state encoding for the RPN stack sequencer.
package rpn_pkg;

  localparam logic [2:0] OP_PUSH = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_MUL  = 3'd3;
  localparam logic [2:0] OP_AND  = 3'd4;
  localparam logic [2:0] OP_POP  = 3'd5;
  localparam logic [2:0] OP_CLR  = 3'd6;
  localparam logic [2:0] OP_DUP  = 3'd7;

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_UNDER   = 2'd1;
  localparam logic [1:0] ERR_OVER    = 2'd2;
  localparam logic [1:0] ERR_ILLEGAL = 2'd3;

  // ST_SP_UPD is the shared first step of POP and CLR, where the pointer moves.
  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_PUSH_WR = 4'd1,
    ST_RD_B    = 4'd2,
    ST_RD_A    = 4'd3,
    ST_EXEC    = 4'd4,
    ST_RES_WR  = 4'd5,
    ST_SP_UPD  = 4'd6,
    ST_POP_RD  = 4'd7,
    ST_POP_CAP = 4'd8,
    ST_RETIRE  = 4'd9
  } state_t;

endpackage

// File: rtl/rpn_stack_ctrl_if.sv
// Command, stack-RAM and status bundle of the RPN stack sequencer.
// slave = sequencer side, master = front-end / RAM side.
interface rpn_stack_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_op;
  logic [DATA_W-1:0] cmd_data;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [ADDR_W:0]   sp;
  logic [DATA_W-1:0] tos;
  logic              done;
  logic [1:0]        err;

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, mem_rdata,
    output cmd_ready, mem_addr, mem_we, mem_wdata, sp, tos, done, err
  );

  modport master (
    output cmd_valid, cmd_op, cmd_data, mem_rdata,
    input  cmd_ready, mem_addr, mem_we, mem_wdata, sp, tos, done, err
  );
endinterface

// File: rtl/rpn_alu.sv
// Combinational ALU for the binary RPN ops; results wrap modulo 2^DATA_W.
module rpn_alu
  import rpn_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] r
);

  // a is the deeper operand, b the former top of stack
  always_comb begin
    r = {DATA_W{1'b0}};
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_MUL:  r = a * b;
      OP_AND:  r = a & b;
      default: r = {DATA_W{1'b0}};
    endcase
  end

endmodule

// File: rtl/rpn_stack_ctrl.sv
// RPN operand-stack sequencer driving a synchronous-read stack RAM; all outputs registered.
// Optional DUP command enabled by defining RPN_DUP_EN.
module rpn_stack_ctrl
  import rpn_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic            CLOCK_50,
  input  logic            reset,
  rpn_stack_ctrl_if.slave bus
);

  localparam int              ADDR_W  = $clog2(DEPTH);
  localparam logic [ADDR_W:0] SP_ZERO = (ADDR_W+1)'(0);
  localparam logic [ADDR_W:0] SP_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] SP_TWO  = (ADDR_W+1)'(2);
  localparam logic [ADDR_W:0] SP_FULL = (ADDR_W+1)'(DEPTH);

  state_t            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [ADDR_W:0]   sp_q, sp_d;
  logic [DATA_W-1:0] tos_q, tos_d;
  logic [1:0]        err_q, err_d;
  logic              done_q, done_d;
  logic              ready_q, ready_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [ADDR_W-1:0] sp_lo_s;
  logic [DATA_W-1:0] alu_r_s;

  // Low address bits of sp; sp-1/sp-2 computed on these stay in range because the guards keep sp>=2.
  assign sp_lo_s = sp_q[ADDR_W-1:0];

  rpn_alu #(.DATA_W(DATA_W)) u_alu (
    .op (op_q),
    .a  (bus.mem_rdata),
    .b  (b_q),
    .r  (alu_r_s)
  );

  // Next-state and next-output logic; outputs are computed one cycle ahead so they leave flops.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    data_d      = data_q;
    b_d         = b_q;
    sp_d        = sp_q;
    tos_d       = tos_q;
    err_d       = err_q;
    done_d      = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          op_d   = bus.cmd_op;
          data_d = bus.cmd_data;
          err_d  = ERR_OK;
          case (bus.cmd_op)
            OP_PUSH: begin
              if (sp_q == SP_FULL) begin
                err_d   = ERR_OVER;
                state_d = ST_RETIRE;
                done_d  = 1'b1;
              end else begin
                state_d     = ST_PUSH_WR;
                mem_we_d    = 1'b1;
                mem_addr_d  = sp_lo_s;
                mem_wdata_d = bus.cmd_data;
              end
            end
            OP_ADD, OP_SUB, OP_MUL, OP_AND: begin
              if (sp_q < SP_TWO) begin
                err_d   = ERR_UNDER;
                state_d = ST_RETIRE;
                done_d  = 1'b1;
              end else begin
                state_d    = ST_RD_B;
                mem_addr_d = sp_lo_s - ADDR_W'(1);
              end
            end
            OP_POP: begin
              if (sp_q == SP_ZERO) begin
                err_d   = ERR_UNDER;
                state_d = ST_RETIRE;
                done_d  = 1'b1;
              end else begin
                state_d = ST_SP_UPD;
              end
            end
            OP_CLR: state_d = ST_SP_UPD;
`ifdef RPN_DUP_EN
            OP_DUP: begin
              if (sp_q == SP_ZERO) begin
                err_d   = ERR_UNDER;
                state_d = ST_RETIRE;
                done_d  = 1'b1;
              end else if (sp_q == SP_FULL) begin
                err_d   = ERR_OVER;
                state_d = ST_RETIRE;
                done_d  = 1'b1;
              end else begin
                data_d      = tos_q;
                state_d     = ST_PUSH_WR;
                mem_we_d    = 1'b1;
                mem_addr_d  = sp_lo_s;
                mem_wdata_d = tos_q;
              end
            end
`else
            OP_DUP: begin
              err_d   = ERR_ILLEGAL;
              state_d = ST_RETIRE;
              done_d  = 1'b1;
            end
`endif
            default: begin
              err_d   = ERR_ILLEGAL;
              state_d = ST_RETIRE;
              done_d  = 1'b1;
            end
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PUSH_WR: begin
        sp_d    = sp_q + SP_ONE;
        tos_d   = data_q;
        state_d = ST_RETIRE;
        done_d  = 1'b1;
      end
      ST_RD_B: begin
        mem_addr_d = sp_lo_s - ADDR_W'(2);
        state_d    = ST_RD_A;
      end
      ST_RD_A: begin
        b_d     = bus.mem_rdata;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        mem_we_d    = 1'b1;
        mem_wdata_d = alu_r_s;
        state_d     = ST_RES_WR;
      end
      ST_RES_WR: begin
        sp_d    = sp_q - SP_ONE;
        tos_d   = mem_wdata_q;
        state_d = ST_RETIRE;
        done_d  = 1'b1;
      end
      ST_SP_UPD: begin
        if (op_q == OP_CLR || sp_q == SP_ONE) begin
          sp_d    = (op_q == OP_CLR) ? SP_ZERO : sp_q - SP_ONE;
          tos_d   = {DATA_W{1'b0}};
          state_d = ST_RETIRE;
          done_d  = 1'b1;
        end else begin
          sp_d       = sp_q - SP_ONE;
          mem_addr_d = sp_lo_s - ADDR_W'(2);
          state_d    = ST_POP_RD;
        end
      end
      ST_POP_RD:  state_d = ST_POP_CAP;
      ST_POP_CAP: begin
        tos_d   = bus.mem_rdata;
        state_d = ST_RETIRE;
        done_d  = 1'b1;
      end
      ST_RETIRE:  state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
    ready_d = (state_d == ST_IDLE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_PUSH;
      data_q      <= {DATA_W{1'b0}};
      b_q         <= {DATA_W{1'b0}};
      sp_q        <= SP_ZERO;
      tos_q       <= {DATA_W{1'b0}};
      err_q       <= ERR_OK;
      done_q      <= 1'b0;
      ready_q     <= 1'b1;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= {ADDR_W{1'b0}};
      mem_wdata_q <= {DATA_W{1'b0}};
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      data_q      <= data_d;
      b_q         <= b_d;
      sp_q        <= sp_d;
      tos_q       <= tos_d;
      err_q       <= err_d;
      done_q      <= done_d;
      ready_q     <= ready_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign bus.cmd_ready = ready_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.sp        = sp_q;
  assign bus.tos       = tos_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule
